// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter for the write port of the async FIFO.
// Optional counters: define FIFO_WR_ARB_STATS_EN to add pkt_cnt/stall_cnt.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]     pkt_cnt,
  output logic [15:0]               stall_cnt,
`endif
  output logic                      busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] gid, gid_nx;
  logic [ID_W-1:0] rr_ptr, rr_nx;
  logic [ID_W-1:0] win;
  logic            win_ok;
  logic            g_valid, g_last, done;
  logic [DATA_W-1:0] g_data;

  assign g_valid = req_valid[gid];
  assign g_last  = req_last[gid];
  assign g_data  = req_data[int'(gid)*DATA_W +: DATA_W];
  assign done    = (state == GRANT) & g_valid & ~fifo_full & g_last;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    idx    = 0;
    win    = '0;
    win_ok = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_ok && req_valid[idx]) begin
        win_ok = 1'b1;
        win    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state  <= IDLE;
      gid    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      gid    <= gid_nx;
      rr_ptr <= rr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gid_nx   = gid;
    rr_nx    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (arb_en && win_ok) begin
          state_nx = GRANT;
          gid_nx   = win;
        end
      end
      GRANT: begin
        if (done) begin
          state_nx = IDLE;
          rr_nx    = (gid == ID_W'(NUM_REQ-1)) ? '0 : gid + ID_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // outputs are forced low in the reset cycle so no beat escapes
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (state == GRANT && !wr_rst) begin
      req_ready[gid] = ~fifo_full;
      fifo_wr_en     = g_valid & ~fifo_full;
      if (g_valid && !fifo_full) fifo_wr_data = g_data;
    end
  end

  assign grant_valid = (state == GRANT) & ~wr_rst;
  assign grant_id    = wr_rst ? '0 : gid;
  assign busy        = grant_valid | (|req_valid);

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == GRANT && g_valid && fifo_full && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done && gid == ID_W'(i) && pkt_cnt[i*16 +: 16] != 16'hFFFF)
          pkt_cnt[i*16 +: 16] <= pkt_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_contract
    assert property (@(posedge wr_clk) disable iff (wr_rst)
      (req_valid[i] && !req_ready[i]) |=> (!req_valid[i] ||
        ($stable(req_data[i*DATA_W +: DATA_W]) && $stable(req_last[i]))))
      else $error("requester %0d changed data/last while stalled", i);
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized + directed bench for fifo_wr_arbiter against a queue-based model.
// Stats outputs are checked when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = $clog2(N);

  logic            wr_clk = 1'b0;
  logic            wr_rst = 1'b1;
  logic            arb_en = 1'b0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] pkt_cnt;
  logic [15:0]     stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .arb_en(arb_en),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
    .pkt_cnt(pkt_cnt),
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  int n_chk = 0;
  int n_err = 0;

  // per-requester beat streams: {last, data}
  logic [DW:0]   q [N][$];
  logic [DW-1:0] wlog [$];
  int seq [N];

  // reference state: who owns the port, where the scan starts
  int m_owner = -1;
  int m_ptr   = 0;
  bit m_gid0  = 1'b1;
  int m_pkt [N];
  int m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int r, input int s);
    return {8'(r), 24'(s)};
  endfunction

  task automatic push_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) begin
      q[r].push_back({(b == len-1), dat(r, seq[r])});
      seq[r]++;
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input bit full,
                       input logic [N-1:0] vm);
    bit            act, ewen, fnd;
    logic [N-1:0]  erdy;
    logic [DW-1:0] edat;
    @(negedge wr_clk);
    wr_rst    = rst;
    arb_en    = en;
    fifo_full = full;
    for (int i = 0; i < N; i++) begin
      if (vm[i] && q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = q[i][0][DW];
        req_data[i*DW +: DW] = q[i][0][DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    #1;
    act  = !rst && m_owner >= 0;
    erdy = '0;
    ewen = 1'b0;
    edat = '0;
    if (act && !full) begin
      erdy[m_owner] = 1'b1;
      ewen = req_valid[m_owner];
      if (ewen) edat = q[m_owner][0][DW-1:0];
    end
    chk("grant_valid", grant_valid, act);
    chk("req_ready", req_ready, erdy);
    chk("fifo_wr_en", fifo_wr_en, ewen);
    chk("fifo_wr_data", fifo_wr_data, edat);
    chk("busy", busy, act || (|req_valid));
    if (act) chk("grant_id", grant_id, m_owner);
    else if (rst || m_gid0) chk("grant_id_rst", grant_id, 0);
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("pkt_cnt", pkt_cnt[i*16 +: 16], m_pkt[i]);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (fifo_wr_en) wlog.push_back(fifo_wr_data);
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_gid0  = 1'b1;
      m_stall = 0;
      for (int i = 0; i < N; i++) m_pkt[i] = 0;
    end else if (m_owner >= 0) begin
      if (full && req_valid[m_owner] && m_stall < 65535) m_stall++;
      if (ewen) begin
        if (q[m_owner][0][DW]) begin
          if (m_pkt[m_owner] < 65535) m_pkt[m_owner]++;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
        if (m_owner >= 0) void'(q[m_owner].pop_front());
        else void'(q[(m_ptr + N - 1) % N].pop_front());
      end
    end else if (en) begin
      fnd = 1'b0;
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (!fnd && req_valid[j]) begin
          fnd     = 1'b1;
          m_owner = j;
          m_gid0  = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int b0, b1, b2;
    for (int i = 0; i < N; i++) begin
      seq[i]   = 0;
      m_pkt[i] = 0;
    end

    cycle(1, 0, 0, '1);
    cycle(1, 1, 0, '1);
    cycle(0, 0, 0, '1);

    // single-beat packets from all three: order 0,1,2,0
    push_pkt(0, 1); push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1);
    wlog.delete();
    repeat (9) cycle(0, 1, 0, '1);
    chk("rr_cnt", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("rr_w0", wlog[0], dat(0, 0));
      chk("rr_w1", wlog[1], dat(1, 0));
      chk("rr_w2", wlog[2], dat(2, 0));
      chk("rr_w3", wlog[3], dat(0, 1));
    end

    // 4-beat packet from req0 locks out req1
    cycle(1, 1, 0, '1);
    b0 = seq[0]; b1 = seq[1];
    push_pkt(0, 4); push_pkt(1, 1);
    wlog.delete();
    repeat (9) cycle(0, 1, 0, '1);
    chk("lock_cnt", wlog.size(), 5);
    if (wlog.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("lock_w", wlog[i], dat(0, b0 + i));
      chk("lock_w4", wlog[4], dat(1, b1));
    end

    // full stall at beat 2 of 3 for 5 cycles
    cycle(1, 1, 0, '1);
    b2 = seq[2];
    push_pkt(2, 3);
    wlog.delete();
    repeat (3) cycle(0, 1, 0, '1);
    repeat (5) cycle(0, 1, 1, '1);
    repeat (3) cycle(0, 1, 0, '1);
    chk("stall_cnt_w", wlog.size(), 3);
    if (wlog.size() == 3) chk("stall_w2", wlog[2], dat(2, b2 + 2));

    // arb_en dropped mid-packet of req1, resume from rr_ptr=2
    cycle(1, 1, 0, '1);
    b1 = seq[1];
    push_pkt(1, 3);
    wlog.delete();
    cycle(0, 1, 0, '1);
    b0 = seq[0];
    push_pkt(0, 1);
    cycle(0, 1, 0, '1);
    repeat (2) cycle(0, 0, 0, '1);
    repeat (4) cycle(0, 0, 0, '1);
    chk("en_hold", wlog.size(), 3);
    b2 = seq[2];
    push_pkt(2, 1);
    repeat (5) cycle(0, 1, 0, '1);
    chk("en_cnt", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("en_w2", wlog[2], dat(1, b1 + 2));
      chk("en_w3", wlog[3], dat(2, b2));
      chk("en_w4", wlog[4], dat(0, b0));
    end

    // reset mid-packet of req0
    cycle(1, 1, 0, '1);
    b0 = seq[0];
    push_pkt(0, 4);
    repeat (3) cycle(0, 1, 0, '1);
    cycle(1, 1, 0, '1);
    b1 = seq[1];
    push_pkt(1, 1);
    wlog.delete();
    repeat (8) cycle(0, 1, 0, '1);
    chk("rst_cnt", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("rst_w0", wlog[0], dat(0, b0 + 2));
      chk("rst_w2", wlog[2], dat(1, b1));
    end

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < N; r++)
        if (q[r].size() < 2 && $urandom_range(3) == 0)
          push_pkt(r, 1 + $urandom_range(3));
      cycle(($urandom_range(499) == 0), ($urandom_range(7) != 0),
            ($urandom_range(3) == 0), N'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
